sensor_poll_scheduler: RTL and testbench
========================================

// Module: sensor_poll_scheduler
// PURPOSE
//  Periodic sequencer for the shared sensor bus. Polls IMU accelerometer, IMU gyroscope and
//  VL53L1 ToF in a fixed order, one outstanding request at a time. Assembles one coherent
//  frame and hands it to the attitude controller with a single-cycle frame_valid strobe.
//  Also tracks per-slot timeouts (sticky faults) and sample-period overruns.
// PARAMETERS
//  DATA_W       4     width of one axis / distance sample
//  PERIOD       1000  sample period in clk cycles (>=2)
//  TIMEOUT_CYC  64    max cycles waiting for bus_ack per slot (>=1)
// PORTS
//  clk          in   1         clock
//  reset        in   1         asynchronous, active-low reset
//  enable       in   1         run periodic polling
//  fault_clr    in   1         clear sticky fault/overrun flags
//  bus_req      out  1         request to shared sensor bus (registered)
//  bus_sel      out  2         slot select: 0=accel 1=gyro 2=dist
//  bus_ack      in   1         slave has valid data on bus_data this cycle
//  bus_data     in   3*DATA_W  {z,y,x}; dist uses [DATA_W-1:0]
//  acc_x/y/z    out  DATA_W    published accelerometer axes
//  gyr_x/y/z    out  DATA_W    published gyroscope axes
//  distance     out  DATA_W    published ToF distance
//  frame_valid  out  1         1-cycle strobe: published outputs updated
//  fault        out  3         sticky per-slot timeout flags [2]=dist [1]=gyro [0]=accel
//  overrun      out  1         sticky: period tick arrived while frame in progress
//  busy         out  1         FSM not in IDLE
// BEHAVIOUR
//  - Reset: all outputs 0, shadow regs 0, period counter 0, FSM=IDLE.
//  - Period counter: counts 0..PERIOD-1 while enable=1; tick at wrap (count==PERIOD-1).
//    enable=0 clears and holds counter at 0; a frame in progress still completes.
//  - FSM: IDLE -> ACC -> GYR -> DIST -> PUB -> IDLE. IDLE leaves only on tick.
//  - Tick in cycle T: bus_req=1 and bus_sel=slot from T+1. Per slot a wait counter
//    starts at 0 on entry, increments each cycle.
//  - bus_ack sampled only while bus_req=1 (ignored otherwise). On ack: capture
//    bus_data into slot shadow regs, bus_req drops next cycle, advance to next slot
//    with bus_req re-asserted the following cycle (1 idle cycle between slots).
//  - Timeout: wait counter reaching TIMEOUT_CYC without ack -> set fault[slot], keep
//    previous shadow value, advance. Ack and timeout same cycle: ack wins, no fault.
//  - PUB: copy all shadows to outputs atomically; frame_valid=1 for exactly that cycle;
//    next cycle IDLE. Outputs never change outside PUB (or reset).
//  - Tick while busy=1: tick dropped, overrun=1; polling resumes on next tick seen in IDLE.
//  - fault_clr: clears fault and overrun; same-cycle new set event wins (flag stays 1).
//  - Reset asserted mid-frame: bus_req deasserts immediately, frame discarded.
//  - Wait counter width $clog2(TIMEOUT_CYC+1); period counter $clog2(PERIOD).
// CONFIGURATION
//  DIST_SENSOR_EN defined: DIST slot present as above.
//  DIST_SENSOR_EN undefined: FSM goes GYR -> PUB; bus_sel never 2; distance held 0;
//    fault[2] tied 0.
// TESTING
//  1 PERIOD=100, ack 3 cycles after each req, data acc=123h gyr=456h dist=7 ->
//    one frame_valid, acc_x=3 acc_y=2 acc_z=1, gyr_x=6.., distance=7, fault=0.
//  2 No ack on gyro slot -> after 64 waits fault=3'b010, gyr_* keep prior frame,
//    frame_valid still pulses, dist slot still polled.
//  3 Ack exactly on the timeout cycle of accel -> data captured, fault[0]=0.
//  4 PERIOD=10, acks after 20 cycles -> overrun=1; fault_clr pulse -> overrun=0;
//    no second request issued while busy.
//  5 reset low during GYR with bus_req=1 -> bus_req=0, all outputs 0 same cycle;
//    after release, first frame starts on first tick.
//  6 Build without DIST_SENSOR_EN -> bus_sel only 0,1; distance=0; frame_valid
//    1 cycle after gyro slot completes.

Source files
------------

// File: rtl/sensor_poll_scheduler_if.sv
// Shared sensor bus between the poll scheduler (master) and the sensor mux (slave).
interface sensor_poll_scheduler_if #(
    parameter int DATA_W = 4
);
    logic                bus_req;
    logic [1:0]          bus_sel;
    logic                bus_ack;
    logic [3*DATA_W-1:0] bus_data;

    modport master (output bus_req, output bus_sel, input bus_ack, input bus_data);
    modport slave  (input bus_req, input bus_sel, output bus_ack, output bus_data);
endinterface

// File: rtl/sensor_poll_scheduler.sv
// Periodic accel/gyro/ToF poller that publishes one coherent frame per sample period.
// Define DIST_SENSOR_EN to include the ToF distance slot; otherwise the frame ends after gyro.
module sensor_poll_scheduler #(
    parameter int DATA_W      = 4,
    parameter int PERIOD      = 1000,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    enable,
    input  logic                    fault_clr,
    sensor_poll_scheduler_if.master bus,
    output logic [DATA_W-1:0]       acc_x,
    output logic [DATA_W-1:0]       acc_y,
    output logic [DATA_W-1:0]       acc_z,
    output logic [DATA_W-1:0]       gyr_x,
    output logic [DATA_W-1:0]       gyr_y,
    output logic [DATA_W-1:0]       gyr_z,
    output logic [DATA_W-1:0]       distance,
    output logic                    frame_valid,
    output logic [2:0]              fault,
    output logic                    overrun,
    output logic                    busy
);
`ifdef DIST_SENSOR_EN
    localparam bit DIST_EN = 1'b1;
`else
    localparam bit DIST_EN = 1'b0;
`endif
    localparam int PC_W = $clog2(PERIOD);
    localparam int WC_W = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {IDLE, ACC, GYR, DIST, PUB} state_t;

    state_t              state, state_nxt;
    logic [PC_W-1:0]     period_cnt;
    logic [WC_W-1:0]     wait_cnt, wait_nxt;
    logic                req_q, req_nxt;
    logic [3*DATA_W-1:0] acc_sh, acc_sh_nxt, gyr_sh, gyr_sh_nxt;
    logic [DATA_W-1:0]   dist_sh, dist_sh_nxt;
    logic [2:0]          fault_q, fault_set;
    logic                tick, ack, tmo;

    assign tick = enable && (period_cnt == PC_W'(PERIOD - 1));
    // ack only counts while our request is actually on the bus; ack beats timeout
    assign ack  = req_q && bus.bus_ack;
    assign tmo  = req_q && !bus.bus_ack && (wait_cnt == WC_W'(TIMEOUT_CYC));
    assign busy = (state != IDLE);

    assign bus.bus_req = req_q;
    assign bus.bus_sel = (state == GYR) ? 2'd1 : (state == DIST) ? 2'd2 : 2'd0;
    assign fault       = {DIST_EN ? fault_q[2] : 1'b0, fault_q[1:0]};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)                period_cnt <= '0;
        else if (!enable || tick)  period_cnt <= '0;
        else                       period_cnt <= period_cnt + 1'b1;
    end

    always_comb begin
        state_nxt   = state;
        req_nxt     = 1'b0;
        wait_nxt    = '0;
        acc_sh_nxt  = acc_sh;
        gyr_sh_nxt  = gyr_sh;
        dist_sh_nxt = dist_sh;
        fault_set   = '0;
        unique case (state)
            IDLE: if (tick) begin
                state_nxt = ACC;
                req_nxt   = 1'b1;
            end
            ACC, GYR, DIST: begin
                if (!req_q) begin
                    // idle gap after the previous slot: raise the request now
                    req_nxt = 1'b1;
                end else if (ack || tmo) begin
                    if (state == ACC) begin
                        state_nxt    = GYR;
                        acc_sh_nxt   = ack ? bus.bus_data : acc_sh;
                        fault_set[0] = tmo;
                    end else if (state == GYR) begin
                        state_nxt    = DIST_EN ? DIST : PUB;
                        gyr_sh_nxt   = ack ? bus.bus_data : gyr_sh;
                        fault_set[1] = tmo;
                    end else begin
                        state_nxt    = PUB;
                        dist_sh_nxt  = ack ? bus.bus_data[DATA_W-1:0] : dist_sh;
                        fault_set[2] = tmo;
                    end
                end else begin
                    req_nxt  = 1'b1;
                    wait_nxt = wait_cnt + 1'b1;
                end
            end
            PUB:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            req_q    <= 1'b0;
            wait_cnt <= '0;
            acc_sh   <= '0;
            gyr_sh   <= '0;
            dist_sh  <= '0;
            fault_q  <= '0;
            overrun  <= 1'b0;
        end else begin
            state    <= state_nxt;
            req_q    <= req_nxt;
            wait_cnt <= wait_nxt;
            acc_sh   <= acc_sh_nxt;
            gyr_sh   <= gyr_sh_nxt;
            dist_sh  <= dist_sh_nxt;
            fault_q  <= fault_set | (fault_clr ? 3'b000 : fault_q);
            overrun  <= (tick && busy) || (overrun && !fault_clr);
        end
    end

    // Publish from the next-shadow values so the PUB cycle already shows the last slot's data.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc_x       <= '0;
            acc_y       <= '0;
            acc_z       <= '0;
            gyr_x       <= '0;
            gyr_y       <= '0;
            gyr_z       <= '0;
            distance    <= '0;
            frame_valid <= 1'b0;
        end else if (state_nxt == PUB) begin
            acc_x       <= acc_sh_nxt[DATA_W-1:0];
            acc_y       <= acc_sh_nxt[2*DATA_W-1:DATA_W];
            acc_z       <= acc_sh_nxt[3*DATA_W-1:2*DATA_W];
            gyr_x       <= gyr_sh_nxt[DATA_W-1:0];
            gyr_y       <= gyr_sh_nxt[2*DATA_W-1:DATA_W];
            gyr_z       <= gyr_sh_nxt[3*DATA_W-1:2*DATA_W];
            distance    <= DIST_EN ? dist_sh_nxt : '0;
            frame_valid <= 1'b1;
        end else begin
            frame_valid <= 1'b0;
        end
    end
endmodule

// File: tb/tb_sensor_poll_scheduler.sv
// Bench for sensor_poll_scheduler: directed and random frames against a transaction-level model.
module tb_sensor_poll_scheduler;
    localparam int DW  = 4;
    localparam int PER = 16;
    localparam int TO  = 8;
`ifdef DIST_SENSOR_EN
    localparam int NS = 3;
`else
    localparam int NS = 2;
`endif

    logic          clk = 1'b0;
    logic          reset, enable, fault_clr;
    logic [DW-1:0] acc_x, acc_y, acc_z, gyr_x, gyr_y, gyr_z, distance;
    logic          frame_valid, overrun, busy;
    logic [2:0]    fault;

    sensor_poll_scheduler_if #(.DATA_W(DW)) bus ();

    sensor_poll_scheduler #(.DATA_W(DW), .PERIOD(PER), .TIMEOUT_CYC(TO)) dut (
        .clk(clk), .reset(reset), .enable(enable), .fault_clr(fault_clr), .bus(bus),
        .acc_x(acc_x), .acc_y(acc_y), .acc_z(acc_z),
        .gyr_x(gyr_x), .gyr_y(gyr_y), .gyr_z(gyr_z), .distance(distance),
        .frame_valid(frame_valid), .fault(fault), .overrun(overrun), .busy(busy)
    );

    always #5 clk = ~clk;

    int              checks = 0, failures = 0;
    int              pc;
    bit              in_frame;
    logic [2:0]      exp_fault, set_fault;
    logic            exp_ovr, set_ovr;
    logic [3*DW-1:0] shadow [3];
    logic [7*DW-1:0] exp_pub;
    int              dly [3];
    logic [3*DW-1:0] dat [3];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7*DW-1:0] pub_obs();
        return {acc_x, acc_y, acc_z, gyr_x, gyr_y, gyr_z, distance};
    endfunction

    function automatic logic [7*DW-1:0] frame_pub();
        logic [DW-1:0] d;
        d = (NS == 3) ? shadow[2][DW-1:0] : '0;
        return {shadow[0][DW-1:0], shadow[0][2*DW-1:DW], shadow[0][3*DW-1:2*DW],
                shadow[1][DW-1:0], shadow[1][2*DW-1:DW], shadow[1][3*DW-1:2*DW], d};
    endfunction

    function automatic bit tick_now();
        return enable && reset && (pc == PER - 1);
    endfunction

    // advance one clock; model flags and period count follow the edge
    task automatic step();
        if (tick_now() && in_frame) set_ovr = 1'b1;
        exp_fault = set_fault | (fault_clr ? 3'b000 : exp_fault);
        exp_ovr   = set_ovr | (exp_ovr & !fault_clr);
        pc        = !enable ? 0 : ((pc == PER - 1) ? 0 : pc + 1);
        @(posedge clk); #1;
        set_fault = '0;
        set_ovr   = 1'b0;
        fault_clr = 1'b0;
    endtask

    task automatic model_reset();
        pc = 0; in_frame = 0; exp_fault = '0; set_fault = '0; exp_ovr = 0; set_ovr = 0;
        exp_pub = '0;
        for (int i = 0; i < 3; i++) shadow[i] = '0;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, "_req"}, bus.bus_req, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_fv"}, frame_valid, 0);
        check({tag, "_pub"}, pub_obs(), 0);
        check({tag, "_fault"}, fault, 0);
        check({tag, "_ovr"}, overrun, 0);
    endtask

    task automatic reset_abort();
        reset = 1'b0; bus.bus_ack = 1'b0; #2;
        reset_checks("abort");
        @(posedge clk); #1;
        reset = 1'b1; fault_clr = 1'b0;
        model_reset();
    endtask

    task automatic idle_checks();
        check("idle_req", bus.bus_req, 0);
        check("idle_busy", busy, 0);
        check("idle_fv", frame_valid, 0);
        check("idle_fault", fault, exp_fault);
        check("idle_ovr", overrun, exp_ovr);
        check("idle_pub", pub_obs(), exp_pub);
    endtask

    task automatic clear_flags();
        enable = 1'b0; step();
        fault_clr = 1'b1; step();
        check("clr_fault", fault, exp_fault);
        check("clr_ovr", overrun, exp_ovr);
        enable = 1'b1;
    endtask

    // one frame using dly[]/dat[]; slave acks slot s at wait count dly[s] (>TO means never)
    task automatic do_frame(input int abort_slot, input int clr_slot, input int drop_slot);
        int n = 0;
        while (!tick_now() && n < 4 * PER) begin
            idle_checks();
            bus.bus_ack  = 1'($urandom);
            bus.bus_data = (3*DW)'($urandom);
            step(); n++;
        end
        step();
        in_frame = 1'b1;
        for (int s = 0; s < NS; s++) begin
            for (int k = 0; k <= TO; k++) begin
                check("req_on", bus.bus_req, 1);
                check("sel", bus.bus_sel, s);
                check("busy_on", busy, 1);
                if (k == 0) check("pub_hold", pub_obs(), exp_pub);
                if (s == abort_slot) begin
                    reset_abort();
                    return;
                end
                if (s == drop_slot && k == 0) enable = 1'b0;
                bus.bus_ack  = (k == dly[s]);
                bus.bus_data = (k == dly[s]) ? dat[s] : (3*DW)'($urandom);
                if (k == dly[s]) shadow[s] = dat[s];
                else if (k == TO) set_fault[s] = 1'b1;
                if ((k == dly[s] || k == TO) && s == clr_slot) fault_clr = 1'b1;
                step();
                bus.bus_ack = 1'b0;
                if (k == dly[s]) break;
            end
            check("req_gap", bus.bus_req, 0);
            if (s < NS - 1) begin
                check("fv_gap", frame_valid, 0);
                bus.bus_ack  = 1'b1;
                bus.bus_data = (3*DW)'($urandom);
                step();
                bus.bus_ack = 1'b0;
            end
        end
        exp_pub = frame_pub();
        check("fv_pub", frame_valid, 1);
        check("pub_data", pub_obs(), exp_pub);
        check("pub_fault", fault, exp_fault);
        check("pub_ovr", overrun, exp_ovr);
        check("pub_busy", busy, 1);
        bus.bus_ack = 1'b1;
        step();
        bus.bus_ack = 1'b0;
        in_frame = 1'b0;
        check("fv_drop", frame_valid, 0);
        check("busy_drop", busy, 0);
    endtask

    initial begin
        reset = 1'b0; enable = 1'b0; fault_clr = 1'b0;
        bus.bus_ack = 1'b0; bus.bus_data = '0;
        model_reset();
        #2;
        reset_checks("reset");
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1; enable = 1'b1;

        // nominal frame
        dly = '{3, 3, 3}; dat = '{12'h123, 12'h456, 12'h007};
        do_frame(-1, -1, -1);
        check("t1_acc_x", acc_x, 3);
        check("t1_acc_z", acc_z, 1);
        check("t1_gyr_x", gyr_x, 6);
        check("t1_dist", distance, (NS == 3) ? 7 : 0);
        check("t1_fault", fault, 0);

        // gyro never answers: fault[1], gyro keeps previous frame
        dly = '{1, TO + 1, 2}; dat = '{12'h9ab, 12'hcde, 12'h005};
        do_frame(-1, -1, -1);
        check("t2_fault", fault, 3'b010);
        check("t2_gyr_x", gyr_x, 6);
        check("t2_acc_x", acc_x, 4'hb);

        // accel ack on the very timeout cycle
        dly = '{TO, 0, 0}; dat = '{12'h321, 12'h654, 12'h003};
        do_frame(-1, -1, -1);
        check("t3_acc_x", acc_x, 1);
        check("t3_fault", fault, 3'b010);
        clear_flags();

        // slow acks overrun the period
        dly = '{TO, TO, TO}; dat = '{12'h111, 12'h222, 12'h003};
        do_frame(-1, -1, -1);
        check("t4_ovr", overrun, 1);
        clear_flags();
        check("t4_ovr_clr", overrun, 0);

        // clear and new timeout in the same cycle: new fault survives
        dly = '{1, TO + 1, 1};
        do_frame(-1, -1, -1);
        dly = '{TO + 1, 0, 0};
        do_frame(-1, 0, -1);
        check("t5_fault", fault, 3'b001);

        // enable dropped mid-frame: frame still completes
        dly = '{0, 2, 1}; dat = '{12'hfed, 12'hcba, 12'h009};
        do_frame(-1, -1, 1);
        enable = 1'b1;

        // reset mid gyro slot, then first frame after release
        dly = '{1, 0, 0};
        do_frame(1, -1, -1);
        dly = '{2, 1, 0}; dat = '{12'h5a5, 12'ha5a, 12'h00c};
        do_frame(-1, -1, -1);
        check("t6_gyr_y", gyr_y, 4'h5);

        repeat (12) begin
            for (int s = 0; s < 3; s++) begin
                dly[s] = ($urandom_range(0, 3) == 0) ? TO + 1 : int'($urandom_range(0, TO));
                dat[s] = (3*DW)'($urandom);
            end
            do_frame(-1, ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, NS - 1)) : -1, -1);
            if ($urandom_range(0, 2) == 0) clear_flags();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
